// File: rtl/count_seq_pkg.sv
// Shared types for the count-stream sequence checker.
// The state encoding is visible on state_o, so the values are fixed here.
package count_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACQ    = 2'b01,
      LOCKED = 2'b10,
      ERR    = 2'b11
   } state_e;

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating event counter with a synchronous clear.
// Clear takes priority over a same-cycle increment.
module sat_counter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [N-1:0] q
);

   localparam logic [N-1:0] MAX_VAL = {N{1'b1}};

   logic [N-1:0] q_r;

   // count register: reset, then clear, then saturating increment
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q_r <= {N{1'b0}};
      end else if (clr) begin
         q_r <= {N{1'b0}};
      end else if (inc && (q_r != MAX_VAL)) begin
         q_r <= q_r + {{(N-1){1'b0}}, 1'b1};
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/count_seq_checker.sv
// Receive-side monitor for a free-running W-bit count stream: tracks lock to the
// +1 mod 2^W sequence and keeps saturating error and wrap statistics.
module count_seq_checker
   import count_seq_pkg::*;
#(
   parameter int W      = 2,
   parameter int LOCK_N = 3,
   parameter int ERRW   = 8,
   parameter int WRAPW  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cnt_valid,
   input  logic [W-1:0]     cnt_in,
   input  logic             stats_clr,
   output logic             locked,
   output logic             err,
   output logic [1:0]       state_o,
   output logic [ERRW-1:0]  err_count,
   output logic [WRAPW-1:0] wrap_count
);

   localparam int RW = $clog2(LOCK_N + 1);

   state_e          state_r;
   state_e          state_nxt_s;
   logic [W-1:0]    last_r;
   logic [RW-1:0]   run_r;
   logic [RW-1:0]   run_nxt_s;
   logic [RW-1:0]   run_inc_s;
   logic [W-1:0]    expect_s;
   logic            match_s;
   logic            err_inc_s;
   logic            wrap_inc_s;

   // W-bit addition wraps naturally, giving the mod 2^W successor
   assign expect_s  = last_r + {{(W-1){1'b0}}, 1'b1};
   assign match_s   = cnt_valid && (cnt_in == expect_s);
   assign run_inc_s = run_r + {{(RW-1){1'b0}}, 1'b1};

   // state, run length and last sample registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= IDLE;
         run_r   <= {RW{1'b0}};
         last_r  <= {W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         run_r   <= run_nxt_s;
         if (cnt_valid) begin
            last_r <= cnt_in;
         end else begin
            last_r <= last_r;
         end
      end
   end

   // next-state, run update and statistic increment requests
   always_comb begin
      state_nxt_s = state_r;
      run_nxt_s   = run_r;
      err_inc_s   = 1'b0;
      wrap_inc_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (cnt_valid) begin
               state_nxt_s = ACQ;
               run_nxt_s   = {{(RW-1){1'b0}}, 1'b1};
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACQ: begin
            if (match_s) begin
               run_nxt_s = run_inc_s;
               if (run_inc_s == RW'(LOCK_N)) begin
                  state_nxt_s = LOCKED;
               end else begin
                  state_nxt_s = ACQ;
               end
            end else if (cnt_valid) begin
               run_nxt_s = {{(RW-1){1'b0}}, 1'b1};
            end else begin
               run_nxt_s = run_r;
            end
         end
         LOCKED: begin
            if (match_s) begin
               wrap_inc_s = (cnt_in == {W{1'b0}});
            end else if (cnt_valid) begin
               state_nxt_s = ERR;
               err_inc_s   = 1'b1;
            end else begin
               state_nxt_s = LOCKED;
            end
         end
         ERR: begin
            // ERR lasts exactly one cycle; an in-sequence sample counts as a run of two
            if (match_s) begin
               run_nxt_s = RW'(2);
               if (LOCK_N == 2) begin
                  state_nxt_s = LOCKED;
               end else begin
                  state_nxt_s = ACQ;
               end
            end else begin
               state_nxt_s = ACQ;
               run_nxt_s   = {{(RW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = IDLE;
            run_nxt_s   = {RW{1'b0}};
         end
      endcase
   end

   assign locked  = (state_r == LOCKED);
   assign err     = (state_r == ERR);
   assign state_o = state_r;

   sat_counter #(.N(ERRW)) u_err_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (stats_clr),
      .inc     (err_inc_s),
      .q       (err_count)
   );

   sat_counter #(.N(WRAPW)) u_wrap_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (stats_clr),
      .inc     (wrap_inc_s),
      .q       (wrap_count)
   );

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker (W=2, LOCK_N=3, 8-bit counters).
module tb_count_seq_checker;

   logic       clk;
   logic       reset_n;
   logic       cnt_valid;
   logic [1:0] cnt_in;
   logic       stats_clr;
   logic       locked;
   logic       err;
   logic [1:0] state_o;
   logic [7:0] err_count;
   logic [7:0] wrap_count;

   int checks;
   int failures;

   count_seq_checker #(.W(2), .LOCK_N(3), .ERRW(8), .WRAPW(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cnt_valid  (cnt_valid),
      .cnt_in     (cnt_in),
      .stats_clr  (stats_clr),
      .locked     (locked),
      .err        (err),
      .state_o    (state_o),
      .err_count  (err_count),
      .wrap_count (wrap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic v, input logic [1:0] d);
      @(negedge clk);
      cnt_valid = v;
      cnt_in    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [1:0] vals [3];
      vals[0] = 2'd0; vals[1] = 2'd1; vals[2] = 2'd2;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, vals[i]);
         checks++;
         if ({state_o, locked, err, err_count, wrap_count} !== 20'h0) begin
            failures++;
            $display("FAIL reset_hold i=%0d got st=%b lk=%b er=%b ec=%0d wc=%0d exp all 0",
                     i, state_o, locked, err, err_count, wrap_count);
         end
      end
      reset_n = 1'b1;
      step(1'b0, 2'd0);
      checks++;
      if ({state_o, locked, err} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle got %b exp 0000", {state_o, locked, err});
      end
   endtask

   task automatic test_acquire();
      step(1'b1, 2'd0);
      checks++;
      if ({state_o, locked, err} !== 4'b0100) begin
         failures++;
         $display("FAIL acq_first got %b exp 0100", {state_o, locked, err});
      end
      step(1'b1, 2'd1);
      checks++;
      if ({state_o, locked, err} !== 4'b0100) begin
         failures++;
         $display("FAIL acq_second got %b exp 0100", {state_o, locked, err});
      end
      step(1'b1, 2'd2);
      checks++;
      if ({state_o, locked, err} !== 4'b1010) begin
         failures++;
         $display("FAIL acq_lock got %b exp 1010", {state_o, locked, err});
      end
   endtask

   task automatic test_wrap();
      logic [1:0] vals [6];
      logic [7:0] exp_wc [6];
      vals[0] = 2'd3; vals[1] = 2'd0; vals[2] = 2'd1;
      vals[3] = 2'd2; vals[4] = 2'd3; vals[5] = 2'd0;
      exp_wc[0] = 8'd0; exp_wc[1] = 8'd1; exp_wc[2] = 8'd1;
      exp_wc[3] = 8'd1; exp_wc[4] = 8'd1; exp_wc[5] = 8'd2;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, vals[i]);
         checks++;
         if ({locked, err} !== 2'b10 || wrap_count !== exp_wc[i]) begin
            failures++;
            $display("FAIL wrap i=%0d got lk=%b er=%b wc=%0d exp lk=1 er=0 wc=%0d",
                     i, locked, err, wrap_count, exp_wc[i]);
         end
      end
   endtask

   task automatic test_error();
      step(1'b1, 2'd1);
      step(1'b1, 2'd3);
      checks++;
      if ({state_o, locked, err} !== 4'b1101 || err_count !== 8'd1) begin
         failures++;
         $display("FAIL err_pulse got %b ec=%0d exp 1101 ec=1", {state_o, locked, err}, err_count);
      end
      step(1'b1, 2'd0);
      checks++;
      if ({state_o, locked, err} !== 4'b0100) begin
         failures++;
         $display("FAIL err_one_cycle got %b exp 0100", {state_o, locked, err});
      end
      step(1'b1, 2'd1);
      checks++;
      if ({state_o, locked, err} !== 4'b1010 || err_count !== 8'd1 || wrap_count !== 8'd2) begin
         failures++;
         $display("FAIL err_relock got %b ec=%0d wc=%0d exp 1010 ec=1 wc=2",
                  {state_o, locked, err}, err_count, wrap_count);
      end
   endtask

   task automatic test_err_no_valid();
      step(1'b1, 2'd3);
      step(1'b0, 2'd0);
      checks++;
      if ({state_o, locked, err} !== 4'b0100 || err_count !== 8'd2) begin
         failures++;
         $display("FAIL err_gap got %b ec=%0d exp 0100 ec=2", {state_o, locked, err}, err_count);
      end
      step(1'b1, 2'd0);
      step(1'b1, 2'd1);
      checks++;
      if ({state_o, locked, err} !== 4'b1010) begin
         failures++;
         $display("FAIL err_gap_relock got %b exp 1010", {state_o, locked, err});
      end
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 2'd3);
         checks++;
         if ({state_o, locked, err} !== 4'b1010) begin
            failures++;
            $display("FAIL gap_hold i=%0d got %b exp 1010", i, {state_o, locked, err});
         end
      end
      step(1'b1, 2'd2);
      checks++;
      if ({state_o, locked, err} !== 4'b1010 || err_count !== 8'd2) begin
         failures++;
         $display("FAIL gap_resume got %b ec=%0d exp 1010 ec=2", {state_o, locked, err}, err_count);
      end
   endtask

   task automatic test_stats_clr();
      stats_clr = 1'b1;
      step(1'b1, 2'd0);
      stats_clr = 1'b0;
      checks++;
      if ({state_o, locked, err} !== 4'b1101 || err_count !== 8'd0 || wrap_count !== 8'd0) begin
         failures++;
         $display("FAIL clr_err got %b ec=%0d wc=%0d exp 1101 ec=0 wc=0",
                  {state_o, locked, err}, err_count, wrap_count);
      end
      step(1'b1, 2'd1);
      step(1'b1, 2'd2);
      checks++;
      if ({state_o, locked, err} !== 4'b1010 || err_count !== 8'd0) begin
         failures++;
         $display("FAIL clr_relock got %b ec=%0d exp 1010 ec=0", {state_o, locked, err}, err_count);
      end
   endtask

   task automatic test_saturation();
      // each pass from last=2: 0 breaks lock, 1 and 2 re-acquire -> one error per pass
      for (int i = 0; i < 254; i++) begin
         step(1'b1, 2'd0);
         step(1'b1, 2'd1);
         step(1'b1, 2'd2);
      end
      checks++;
      if (err_count !== 8'hFE || wrap_count !== 8'd0) begin
         failures++;
         $display("FAIL sat_pre got ec=%h wc=%0d exp ec=fe wc=0", err_count, wrap_count);
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 2'd0);
         step(1'b1, 2'd1);
         step(1'b1, 2'd2);
      end
      checks++;
      if (err_count !== 8'hFF || locked !== 1'b1) begin
         failures++;
         $display("FAIL sat_hold got ec=%h lk=%b exp ec=ff lk=1", err_count, locked);
      end
   endtask

   task automatic test_reset_wins();
      reset_n   = 1'b0;
      stats_clr = 1'b0;
      step(1'b1, 2'd3);
      checks++;
      if ({state_o, locked, err, err_count, wrap_count} !== 20'h0) begin
         failures++;
         $display("FAIL reset_wins got st=%b lk=%b ec=%h wc=%h exp all 0",
                  state_o, locked, err_count, wrap_count);
      end
      reset_n = 1'b1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset_n   = 1'b0;
      cnt_valid = 1'b0;
      cnt_in    = 2'd0;
      stats_clr = 1'b0;
      test_reset();
      test_acquire();
      test_wrap();
      test_error();
      test_err_no_valid();
      test_gaps();
      test_stats_clr();
      test_saturation();
      test_reset_wins();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
